// File: rtl/lz4_pkg.sv
// Shared constants and FSM encoding for the LZ4 hash-lookup feeder.
package lz4_pkg;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned ISSUE_GAP   = 2;
    localparam int unsigned BLOCK_BYTES = 65536;
    localparam int unsigned SKIP_W      = 16;
    localparam int unsigned WIN_BYTES   = 4;
    localparam int unsigned WIN_W       = 8 * WIN_BYTES;
    localparam int unsigned FILL_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAN_REQ  = 3'd1,
        ST_CLEAN_WAIT = 3'd2,
        ST_RUN        = 3'd3,
        ST_DONE       = 3'd4
    } feeder_state_e;
endpackage

// File: rtl/lz4_byte_window.sv
// 4-byte little-endian shift window: newest byte enters at the top, fill saturates at 4.
module lz4_byte_window
    import lz4_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              clr,
    input  logic              shift,
    input  logic [7:0]        byte_in,
    output logic [WIN_W-1:0]  win_next_c,
    output logic [FILL_W-1:0] fill
);
    logic [WIN_W-1:0] win;

    // Window contents as they will be after shifting byte_in in
    assign win_next_c = {byte_in, win[WIN_W-1:8]};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            win  <= '0;
            fill <= '0;
        end else if (clr) begin
            win  <= '0;
            fill <= '0;
        end else if (shift) begin
            win <= win_next_c;
            if (fill != FILL_W'(WIN_BYTES)) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end
endmodule

// File: rtl/lz4_hash_feeder.sv
// Streams block bytes into a 4-byte window and issues paced hash-table lookups,
// honouring skip requests from the match stage and a table clean at block start.
module lz4_hash_feeder #(
    parameter int unsigned ADDR_W    = lz4_pkg::ADDR_W,
    parameter int unsigned ISSUE_GAP = lz4_pkg::ISSUE_GAP
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        blk_start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    input  logic [15:0] skip_len,
    input  logic        skip_valid,
    output logic        hash_clean,
    input  logic        hash_unable,
    output logic [31:0] hash_idata,
    output logic [31:0] hash_iaddr,
    output logic        hash_ivalid,
    output logic        blk_done
);
    import lz4_pkg::*;

    localparam int unsigned GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = (ISSUE_GAP > 1) ? GAP_W'(ISSUE_GAP - 1) : '0;

    feeder_state_e      state;
    logic [ADDR_W-1:0]  byte_cnt;
    logic [SKIP_W-1:0]  skip_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               seen_busy;

    logic [WIN_W-1:0]   win_next_c;
    logic [FILL_W-1:0]  fill;
    logic               accept_c;
    logic               end_c;
    logic               skip_c;
    logic               issue_c;
    logic [SKIP_W-1:0]  skip_nxt_c;
    logic [GAP_W-1:0]   gap_nxt_c;

    lz4_byte_window u_window (
        .clk        (clk),
        .rstN       (rstN),
        .clr        (state == ST_CLEAN_REQ),
        .shift      (accept_c),
        .byte_in    (byte_in),
        .win_next_c (win_next_c),
        .fill       (fill)
    );

    // Per-byte decisions: acceptance, block end, skipping, lookup issue and pacing
    always_comb begin
        accept_c   = (state == ST_RUN) && byte_valid && byte_ready;
        end_c      = accept_c && (byte_last || (byte_cnt == {ADDR_W{1'b1}}));
        skip_c     = skip_valid ? (skip_len != '0) : (skip_cnt != '0);
        issue_c    = accept_c && !skip_c && (fill >= FILL_W'(WIN_BYTES - 1));
        skip_nxt_c = skip_cnt;
        if (skip_valid) begin
            skip_nxt_c = (accept_c && (skip_len != '0)) ? skip_len - SKIP_W'(1) : skip_len;
        end else if (accept_c && (skip_cnt != '0)) begin
            skip_nxt_c = skip_cnt - SKIP_W'(1);
        end
        gap_nxt_c = '0;
        if (issue_c) begin
            gap_nxt_c = GAP_RELOAD;
        end else if (gap_cnt != '0) begin
            gap_nxt_c = gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            skip_cnt    <= '0;
            gap_cnt     <= '0;
            seen_busy   <= 1'b0;
            byte_ready  <= 1'b0;
            hash_clean  <= 1'b0;
            hash_ivalid <= 1'b0;
            hash_idata  <= '0;
            hash_iaddr  <= '0;
            blk_done    <= 1'b0;
        end else begin
            hash_clean  <= 1'b0;
            hash_ivalid <= 1'b0;
            blk_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    byte_ready <= 1'b0;
                    if (blk_start) begin
                        state      <= ST_CLEAN_REQ;
                        hash_clean <= 1'b1;
                    end
                end
                ST_CLEAN_REQ: begin
                    seen_busy <= hash_unable;
                    state     <= ST_CLEAN_WAIT;
                end
                // Table must go busy and come back before any lookup is allowed
                ST_CLEAN_WAIT: begin
                    if (hash_unable) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state      <= ST_RUN;
                        byte_cnt   <= '0;
                        skip_cnt   <= '0;
                        gap_cnt    <= '0;
                        byte_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    skip_cnt    <= skip_nxt_c;
                    gap_cnt     <= gap_nxt_c;
                    hash_ivalid <= issue_c;
                    if (issue_c) begin
                        hash_idata <= win_next_c;
                        hash_iaddr <= 32'(byte_cnt - ADDR_W'(3));
                    end
                    if (end_c) begin
                        state      <= ST_DONE;
                        skip_cnt   <= '0;
                        gap_cnt    <= '0;
                        byte_ready <= 1'b0;
                    end else begin
                        if (accept_c) begin
                            byte_cnt <= byte_cnt + ADDR_W'(1);
                        end
                        byte_ready <= (gap_nxt_c == '0) && !hash_unable;
                    end
                end
                ST_DONE: begin
                    blk_done <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
